game_flow_fsm: RTL and testbench
================================

Name: game_flow_fsm

Overview:
- Parametrised top-level game-flow controller for Doodle Jump: menu → loading → game ↔ pause/refresh → game over.
- Adds multi-life respawn, a game-over auto-return timer, a refresh watchdog, and key-press edge qualification.
- All timing is in frames, counted from a synchronously sampled frame_clk.
- Drives outstate for the VGA/sprite muxes and loadplat for the platform generator.

Parameters:
- LOAD_FRAMES, 60, frame ticks spent in LOADING before GAME (≥1)
- OVER_FRAMES, 180, frame ticks in GAME_OVER before auto-return to INIT (≥1)
- REFRESH_TIMEOUT, 16, frame ticks REFRESHING waits for trigger before forced exit (≥1)
- LIVES, 3, lives per new game (1..7)
- KEY_START, 8'd44, keycode that starts a game (space)
- KEY_PAUSE, 8'd41, keycode for pause and game-over exit (esc)

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  VGA frame strobe; rising edge sampled on Clock
- Keycode  in  8  current USB keycode, 0 = no key
- trigger  in  1  refresh-complete from the platform generator
- refresh_en  in  1  refresh request from game logic
- game_over_trigger  in  1  player death
- outstate  out  3  state code
- loadplat  out  1  high throughout LOADING
- lives_left  out  3  remaining lives
- refresh_err  out  1  sticky flag: a refresh watchdog expired

Behaviour:
- Reset values:
  - state=INIT, outstate=3'b101, loadplat=0, lives_left=LIVES, refresh_err=0
  - frame counter=0, key/frame history registers=0
- frame_tick: one Clock pulse when frame_clk is 1 this cycle and 0 the previous cycle.
- key_press: one Clock pulse when Keycode≠0 and Keycode≠Keycode of the previous cycle.
  - A held key never re-fires.
- Frame counter:
  - Clears on every state change.
  - Otherwise increments on frame_tick and saturates at its maximum.
  - Width = $clog2(max(LOAD_FRAMES, OVER_FRAMES, REFRESH_TIMEOUT)+1).
- outstate is decoded combinationally from the state register, so it changes the cycle after the transition condition.
  - INIT 101, MAIN_MENU 000, LOADING 001, GAME 010, PAUSE 011, REFRESHING 100, GAME_OVER 110.
- Transitions (evaluated each Clock cycle):
  - INIT → MAIN_MENU unconditionally; lives_left is reloaded to LIVES.
  - MAIN_MENU → LOADING on key_press with Keycode==KEY_START.
  - LOADING → GAME when counter==LOAD_FRAMES.
  - GAME, priority high to low:
    - game_over_trigger: lives_left decrements. If the pre-decrement value is 1, go to GAME_OVER; otherwise go to LOADING (respawn, loadplat reasserts).
    - key_press with Keycode==KEY_PAUSE → PAUSE.
    - refresh_en → REFRESHING.
  - PAUSE → GAME on any key_press.
    - The esc still held from entry does not exit.
    - Inputs game_over_trigger and refresh_en are ignored in PAUSE.
  - REFRESHING:
    - trigger → GAME.
    - Else counter==REFRESH_TIMEOUT → GAME with refresh_err set.
    - trigger wins if both occur in the same cycle; refresh_err is then not set.
  - GAME_OVER → INIT on key_press with Keycode==KEY_PAUSE, or when counter==OVER_FRAMES, whichever comes first.
- refresh_err clears only on Reset or on the INIT state.
- lives_left never underflows; it stays at 0 in GAME_OVER until INIT.
- Reset asserted mid-operation returns to INIT on the next edge, regardless of state or counters.
- Any unreachable state encoding → INIT.

Decomposition:
- Package game_flow_pkg holds:
  - state enum game_state_t (3-bit, encodings above)
  - outstate code localparams
  - KEY_SPACE=8'd44, KEY_ESC=8'd41
- Sub-module frame_tick_gen: frame_clk sampler/edge detector producing frame_tick.
- Key-press qualification and the frame counter stay inline.
- Expected size is about 200 lines.

Test Plan (bench params LOAD_FRAMES=4, OVER_FRAMES=6, REFRESH_TIMEOUT=3, LIVES=2):
- Reset, then Keycode=44 for 1 cycle → outstate 101→000→001; loadplat=1 for exactly 4 frame ticks; then outstate=010, loadplat=0.
- In GAME, hold Keycode=41 for 20 cycles → PAUSE (011) entered once and held. Release, then press Keycode=4 → GAME (010).
- In GAME, game_over_trigger and esc press in the same cycle → LOADING (001), lives_left 2→1. A second game_over_trigger → GAME_OVER (110), lives_left=0.
- GAME_OVER with no keys → INIT (101) after 6 frame ticks, then MAIN_MENU with lives_left=2.
- refresh_en with no trigger → REFRESHING (100) for 3 frame ticks, then GAME with refresh_err=1. Repeat with trigger on the timeout cycle → refresh_err unchanged.
- Reset asserted for 1 cycle mid-LOADING at counter=2 → INIT next cycle, loadplat=0, refresh_err=0, lives_left=2.

Source files
------------

// File: rtl/game_flow_pkg.sv
// Shared types and constants for the Doodle Jump game-flow controller.
// State codes double as the outstate codes seen by the VGA muxes.
package game_flow_pkg;

  typedef enum logic [2:0] {
    ST_MAIN_MENU  = 3'b000,
    ST_LOADING    = 3'b001,
    ST_GAME       = 3'b010,
    ST_PAUSE      = 3'b011,
    ST_REFRESHING = 3'b100,
    ST_INIT       = 3'b101,
    ST_GAME_OVER  = 3'b110
  } game_state_t;

  localparam logic [2:0] OS_MAIN_MENU  = 3'b000;
  localparam logic [2:0] OS_LOADING    = 3'b001;
  localparam logic [2:0] OS_GAME       = 3'b010;
  localparam logic [2:0] OS_PAUSE      = 3'b011;
  localparam logic [2:0] OS_REFRESHING = 3'b100;
  localparam logic [2:0] OS_INIT       = 3'b101;
  localparam logic [2:0] OS_GAME_OVER  = 3'b110;

  localparam logic [7:0] KEY_SPACE = 8'd44;
  localparam logic [7:0] KEY_ESC   = 8'd41;

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/game_flow_fsm_frame_tick_gen.sv
// Frame strobe sampler: turns the VGA frame_clk level into a
// single Clock-wide pulse on its rising edge.
module frame_tick_gen (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_frame_clk,
  output logic o_frame_tick
);

  logic r_frame_prev;

  // remember last cycle's frame_clk level
  always_ff @(posedge i_clk) begin
    if (i_rst) r_frame_prev <= 1'b0;
    else       r_frame_prev <= i_frame_clk;
  end

  assign o_frame_tick = i_frame_clk & ~r_frame_prev;

endmodule

// File: rtl/game_flow_fsm.sv
// Top-level game-flow controller: menu, loading, game, pause,
// refresh and game over, with lives, timers and a refresh watchdog.
module game_flow_fsm
  import game_flow_pkg::*;
#(
  parameter int unsigned LOAD_FRAMES     = 60,
  parameter int unsigned OVER_FRAMES     = 180,
  parameter int unsigned REFRESH_TIMEOUT = 16,
  parameter int unsigned LIVES           = 3,
  parameter logic [7:0]  KEY_START       = KEY_SPACE,
  parameter logic [7:0]  KEY_PAUSE       = KEY_ESC
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] Keycode,
  input  logic       trigger,
  input  logic       refresh_en,
  input  logic       game_over_trigger,
  output logic [2:0] outstate,
  output logic       loadplat,
  output logic [2:0] lives_left,
  output logic       refresh_err
);

  localparam int unsigned CNT_TOP =
    max3(LOAD_FRAMES, OVER_FRAMES, REFRESH_TIMEOUT);
  localparam int CW = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] C_LOAD = CW'(LOAD_FRAMES);
  localparam logic [CW-1:0] C_OVER = CW'(OVER_FRAMES);
  localparam logic [CW-1:0] C_REF  = CW'(REFRESH_TIMEOUT);
  localparam logic [CW-1:0] C_MAX  = {CW{1'b1}};
  localparam logic [2:0]    C_LIVES = 3'(LIVES);

  game_state_t   r_state;
  game_state_t   w_next;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_key_prev;
  logic [2:0]    r_lives;
  logic          r_err;
  logic          w_frame_tick;
  logic          w_key_press;
  logic          w_start_key;
  logic          w_pause_key;
  logic          w_lives_dec;
  logic          w_set_err;

  frame_tick_gen u_tick (
    .i_clk        (Clock),
    .i_rst        (Reset),
    .i_frame_clk  (frame_clk),
    .o_frame_tick (w_frame_tick)
  );

  assign w_key_press = (Keycode != 8'd0) && (Keycode != r_key_prev);
  assign w_start_key = w_key_press && (Keycode == KEY_START);
  assign w_pause_key = w_key_press && (Keycode == KEY_PAUSE);

  // previous keycode, so a held key fires only once
  always_ff @(posedge Clock) begin
    if (Reset) r_key_prev <= 8'd0;
    else       r_key_prev <= Keycode;
  end

  // state register
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= ST_INIT;
    else       r_state <= w_next;
  end

  // next-state logic plus lives/watchdog side effects
  always_comb begin
    w_next      = r_state;
    w_lives_dec = 1'b0;
    w_set_err   = 1'b0;
    unique case (r_state)
      ST_INIT: w_next = ST_MAIN_MENU;
      ST_MAIN_MENU: begin
        if (w_start_key) w_next = ST_LOADING;
      end
      ST_LOADING: begin
        if (r_cnt == C_LOAD) w_next = ST_GAME;
      end
      ST_GAME: begin
        if (game_over_trigger) begin
          w_lives_dec = 1'b1;
          w_next = (r_lives <= 3'd1) ? ST_GAME_OVER
                                     : ST_LOADING;
        end else if (w_pause_key) begin
          w_next = ST_PAUSE;
        end else if (refresh_en) begin
          w_next = ST_REFRESHING;
        end
      end
      ST_PAUSE: begin
        if (w_key_press) w_next = ST_GAME;
      end
      ST_REFRESHING: begin
        if (trigger) begin
          w_next = ST_GAME;
        end else if (r_cnt == C_REF) begin
          w_next    = ST_GAME;
          w_set_err = 1'b1;
        end
      end
      ST_GAME_OVER: begin
        if (w_pause_key || (r_cnt == C_OVER))
          w_next = ST_INIT;
      end
      default: w_next = ST_INIT;
    endcase
  end

  // frame counter: restarts on each state change, saturates
  always_ff @(posedge Clock) begin
    if (Reset)
      r_cnt <= '0;
    else if (w_next != r_state)
      r_cnt <= '0;
    else if (w_frame_tick && (r_cnt != C_MAX))
      r_cnt <= r_cnt + 1'b1;
  end

  // lives: reload on INIT, decrement on death without underflow
  always_ff @(posedge Clock) begin
    if (Reset)
      r_lives <= C_LIVES;
    else if (r_state == ST_INIT)
      r_lives <= C_LIVES;
    else if (w_lives_dec && (r_lives != 3'd0))
      r_lives <= r_lives - 3'd1;
  end

  // sticky watchdog flag, cleared only by reset or INIT
  always_ff @(posedge Clock) begin
    if (Reset)
      r_err <= 1'b0;
    else if (r_state == ST_INIT)
      r_err <= 1'b0;
    else if (w_set_err)
      r_err <= 1'b1;
  end

  // state code decode for the display muxes
  always_comb begin
    outstate = OS_INIT;
    unique case (r_state)
      ST_MAIN_MENU:  outstate = OS_MAIN_MENU;
      ST_LOADING:    outstate = OS_LOADING;
      ST_GAME:       outstate = OS_GAME;
      ST_PAUSE:      outstate = OS_PAUSE;
      ST_REFRESHING: outstate = OS_REFRESHING;
      ST_INIT:       outstate = OS_INIT;
      ST_GAME_OVER:  outstate = OS_GAME_OVER;
      default:       outstate = OS_INIT;
    endcase
  end

  assign loadplat    = (r_state == ST_LOADING);
  assign lives_left  = r_lives;
  assign refresh_err = r_err;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Self-checking bench for game_flow_fsm: directed flow through the
// game plus randomized traffic against a behavioural model.
module tb_game_flow_fsm;

  localparam int LF = 4;
  localparam int OF = 6;
  localparam int RT = 3;
  localparam int LV = 2;
  localparam int CNT_SAT = 7;

  localparam int S_MM = 0;
  localparam int S_LD = 1;
  localparam int S_GM = 2;
  localparam int S_PS = 3;
  localparam int S_RF = 4;
  localparam int S_IN = 5;
  localparam int S_GO = 6;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] Keycode = 8'd0;
  logic       trigger = 1'b0;
  logic       refresh_en = 1'b0;
  logic       game_over_trigger = 1'b0;
  logic [2:0] outstate;
  logic       loadplat;
  logic [2:0] lives_left;
  logic       refresh_err;

  int n_tests = 0;
  int n_fail  = 0;

  int m_st, m_cnt, m_lives, m_err, m_fprev, m_kprev;

  game_flow_fsm #(
    .LOAD_FRAMES     (LF),
    .OVER_FRAMES     (OF),
    .REFRESH_TIMEOUT (RT),
    .LIVES           (LV),
    .KEY_START       (8'd44),
    .KEY_PAUSE       (8'd41)
  ) dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .frame_clk         (frame_clk),
    .Keycode           (Keycode),
    .trigger           (trigger),
    .refresh_en        (refresh_en),
    .game_over_trigger (game_over_trigger),
    .outstate          (outstate),
    .loadplat          (loadplat),
    .lives_left        (lives_left),
    .refresh_err       (refresh_err)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // advance the game model by one Clock using the current inputs
  task automatic model_update();
    bit tick, kp, dec, seterr;
    int nst, k;
    k = int'(Keycode);
    if (Reset) begin
      m_st = S_IN; m_cnt = 0; m_lives = LV; m_err = 0;
      m_fprev = 0; m_kprev = 0;
      return;
    end
    tick = frame_clk && (m_fprev == 0);
    kp = (k != 0) && (k != m_kprev);
    dec = 0; seterr = 0; nst = m_st;
    if (m_st == S_IN) nst = S_MM;
    else if (m_st == S_MM) begin
      if (kp && k == 44) nst = S_LD;
    end else if (m_st == S_LD) begin
      if (m_cnt == LF) nst = S_GM;
    end else if (m_st == S_GM) begin
      if (game_over_trigger) begin
        dec = 1;
        nst = (m_lives > 1) ? S_LD : S_GO;
      end else if (kp && k == 41) nst = S_PS;
      else if (refresh_en) nst = S_RF;
    end else if (m_st == S_PS) begin
      if (kp) nst = S_GM;
    end else if (m_st == S_RF) begin
      if (trigger) nst = S_GM;
      else if (m_cnt == RT) begin nst = S_GM; seterr = 1; end
    end else if (m_st == S_GO) begin
      if ((kp && k == 41) || m_cnt == OF) nst = S_IN;
    end else nst = S_IN;

    if (m_st == S_IN) m_lives = LV;
    else if (dec && m_lives > 0) m_lives = m_lives - 1;
    if (m_st == S_IN) m_err = 0;
    else if (seterr) m_err = 1;
    if (nst != m_st) m_cnt = 0;
    else if (tick && m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
    m_st = nst;
    m_fprev = int'(frame_clk);
    m_kprev = k;
  endtask

  task automatic step();
    model_update();
    @(posedge Clock);
    #1;
    chk("outstate", int'(outstate), m_st);
    chk("loadplat", int'(loadplat), (m_st == S_LD) ? 1 : 0);
    chk("lives", int'(lives_left), m_lives);
    chk("refresh_err", int'(refresh_err), m_err);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1; step();
      frame_clk = 1'b0; step();
    end
  endtask

  task automatic enter_game();
    Keycode = 8'd44; step();
    Keycode = 8'd0;
    frames(LF);
  endtask

  initial begin
    logic [7:0] keys [6];
    keys = '{8'd0, 8'd0, 8'd0, 8'd44, 8'd41, 8'd4};

    Reset = 1'b1; step();
    Reset = 1'b0;
    chk("plan_reset_os", int'(outstate), 5);
    chk("plan_reset_lives", int'(lives_left), LV);
    step();
    chk("plan_menu_os", int'(outstate), 0);
    Keycode = 8'd44; step();
    chk("plan_loading_lp", int'(loadplat), 1);
    Keycode = 8'd0;
    frames(LF);
    chk("plan_game_os", int'(outstate), 2);
    chk("plan_game_lp", int'(loadplat), 0);

    Keycode = 8'd41;
    for (int i = 0; i < 20; i++) step();
    chk("plan_pause_held", int'(outstate), 3);
    Keycode = 8'd0; step();
    Keycode = 8'd4; step();
    Keycode = 8'd0; step();
    chk("plan_unpause", int'(outstate), 2);

    game_over_trigger = 1'b1; Keycode = 8'd41; step();
    game_over_trigger = 1'b0; Keycode = 8'd0;
    chk("plan_respawn_os", int'(outstate), 1);
    chk("plan_respawn_lives", int'(lives_left), 1);
    frames(LF);
    game_over_trigger = 1'b1; step();
    game_over_trigger = 1'b0;
    chk("plan_over_os", int'(outstate), 6);
    chk("plan_over_lives", int'(lives_left), 0);
    frames(OF);
    chk("plan_auto_init", int'(outstate), 5);
    step();
    chk("plan_menu_lives", int'(lives_left), LV);

    enter_game();
    refresh_en = 1'b1; step();
    refresh_en = 1'b0;
    chk("plan_refresh_os", int'(outstate), 4);
    frames(RT);
    chk("plan_wd_os", int'(outstate), 2);
    chk("plan_wd_err", int'(refresh_err), 1);
    refresh_en = 1'b1; step();
    refresh_en = 1'b0;
    frames(RT - 1);
    frame_clk = 1'b1; step();
    frame_clk = 1'b0; trigger = 1'b1; step();
    trigger = 1'b0;
    chk("plan_trig_os", int'(outstate), 2);
    chk("plan_trig_err", int'(refresh_err), 1);

    game_over_trigger = 1'b1; step();
    game_over_trigger = 1'b0;
    frames(2);
    Reset = 1'b1; step();
    Reset = 1'b0;
    chk("plan_midrst_os", int'(outstate), 5);
    chk("plan_midrst_lp", int'(loadplat), 0);
    chk("plan_midrst_err", int'(refresh_err), 0);
    chk("plan_midrst_lives", int'(lives_left), LV);

    for (int i = 0; i < 4000; i++) begin
      Reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
      if ($urandom_range(0, 3) == 0)
        Keycode = keys[$urandom_range(0, 5)];
      trigger = ($urandom_range(0, 7) == 0);
      refresh_en = ($urandom_range(0, 4) == 0);
      game_over_trigger = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
